// File: rtl/ps2_mouse_packet.sv
// PS/2 mouse packet assembler: collects three-byte movement packets, decodes
// buttons and signed deltas, and maintains a clamped screen-space cursor.
module ps2_mouse_packet #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned XMAX           = 255,
    parameter int unsigned YMAX           = 191
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] data,
    output logic [2:0] buttons,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic [7:0] xpos,
    output logic [7:0] ypos,
    output logic       packet_ready,
    output logic       sync_err
);

    // Counter only needs to reach TIMEOUT_CYCLES-1; the idle cycle that would
    // reach the limit is the one that abandons the packet.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] XPOS_RST = 8'(XMAX / 2);
    localparam logic [7:0] YPOS_RST = 8'(YMAX / 2);
    localparam logic [9:0] XMAX_10  = 10'(XMAX);
    localparam logic [9:0] YMAX_10  = 10'(YMAX);

    typedef enum logic [1:0] {
        WAIT0 = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       byte0_q, byte0_n;
    logic [7:0]       byte1_q, byte1_n;
    logic [2:0]       buttons_n;
    logic [8:0]       dx_n, dy_n;
    logic [7:0]       xpos_n, ypos_n;
    logic             packet_ready_n, sync_err_n;

    logic [8:0]       pkt_dx, pkt_dy;
    logic [10:0]      x_sum, y_sum;
    logic [7:0]       x_clamp, y_clamp;
    logic             unused_sync_bit;

    // Bit 3 of byte0 is only a framing marker, consumed before latching.
    assign unused_sync_bit = byte0_q[3];

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT0;
            cnt          <= '0;
            byte0_q      <= '0;
            byte1_q      <= '0;
            buttons      <= '0;
            dx           <= '0;
            dy           <= '0;
            xpos         <= XPOS_RST;
            ypos         <= YPOS_RST;
            packet_ready <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            byte0_q      <= byte0_n;
            byte1_q      <= byte1_n;
            buttons      <= buttons_n;
            dx           <= dx_n;
            dy           <= dy_n;
            xpos         <= xpos_n;
            ypos         <= ypos_n;
            packet_ready <= packet_ready_n;
            sync_err     <= sync_err_n;
        end
    end

    // Packet decode and cursor update, evaluated with data as byte2
    always_comb begin
        pkt_dx = byte0_q[6] ? 9'd0 : {byte0_q[4], byte1_q};
        pkt_dy = byte0_q[7] ? 9'd0 : {byte0_q[5], data};
        x_sum  = {3'b000, xpos} + {{2{pkt_dx[8]}}, pkt_dx};
        y_sum  = {3'b000, ypos} - {{2{pkt_dy[8]}}, pkt_dy};

        if (x_sum[10])
            x_clamp = 8'd0;
        else if (x_sum[9:0] > XMAX_10)
            x_clamp = XMAX_10[7:0];
        else
            x_clamp = x_sum[7:0];

        if (y_sum[10])
            y_clamp = 8'd0;
        else if (y_sum[9:0] > YMAX_10)
            y_clamp = YMAX_10[7:0];
        else
            y_clamp = y_sum[7:0];
    end

    // Next-state and output logic
    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        byte0_n        = byte0_q;
        byte1_n        = byte1_q;
        buttons_n      = buttons;
        dx_n           = dx;
        dy_n           = dy;
        xpos_n         = xpos;
        ypos_n         = ypos;
        packet_ready_n = 1'b0;
        sync_err_n     = 1'b0;

        case (state)
            WAIT0: begin
                cnt_n = '0;
                if (byte_valid) begin
                    if (data[3]) begin
                        byte0_n = data;
                        state_n = WAIT1;
                    end else begin
                        sync_err_n = 1'b1;
                    end
                end
            end
            WAIT1: begin
                if (byte_valid) begin
                    byte1_n = data;
                    cnt_n   = '0;
                    state_n = WAIT2;
                end else if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = WAIT0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            WAIT2: begin
                if (byte_valid) begin
                    cnt_n          = '0;
                    state_n        = WAIT0;
                    buttons_n      = byte0_q[2:0];
                    dx_n           = pkt_dx;
                    dy_n           = pkt_dy;
                    xpos_n         = x_clamp;
                    ypos_n         = y_clamp;
                    packet_ready_n = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = WAIT0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = WAIT0;
            end
        endcase
    end

endmodule

// File: doc/ps2_mouse_packet.md
PS2_MOUSE_PACKET -- requirements
Module: ps2_mouse_packet

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000: maximum clk cycles allowed between bytes of one packet.
REQ-002 Parameter XMAX, default 255: highest legal x position.
REQ-003 Parameter YMAX, default 191: highest legal y position.
REQ-004 clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 byte_valid  input  1  one-cycle strobe from the PS/2 receiver: data holds a new received byte.
REQ-007 data  input  8  received PS/2 byte.
REQ-008 buttons  output  3  {middle, right, left} from the last complete packet.
REQ-009 dx  output  9  signed two's-complement X delta of the last packet, as {X sign, byte1}.
REQ-010 dy  output  9  signed two's-complement Y delta of the last packet, as {Y sign, byte2}.
REQ-011 xpos  output  8  accumulated, clamped X position.
REQ-012 ypos  output  8  accumulated, clamped Y position (screen orientation: down is positive).
REQ-013 packet_ready  output  1  one-cycle pulse when buttons/dx/dy/xpos/ypos update.
REQ-014 sync_err  output  1  one-cycle pulse when a candidate byte0 is discarded.

Function
REQ-015 The block SHALL use the FSM states WAIT0, WAIT1 and WAIT2.
REQ-016 WAIT0 with byte_valid and data[3]=1: the block SHALL latch byte0 and go to WAIT1.
REQ-017 WAIT0 with byte_valid and data[3]=0: the block SHALL discard the byte, pulse sync_err the next cycle and stay in WAIT0.
REQ-018 WAIT1 with byte_valid: the block SHALL latch byte1 and go to WAIT2.
REQ-019 WAIT2 with byte_valid: the block SHALL capture byte2, go to WAIT0 and commit the outputs on that same edge.
REQ-020 packet_ready SHALL be high exactly during the cycle after the byte2 strobe (latency 1 cycle).
REQ-021 byte0 fields: bit0 left, bit1 right, bit2 middle, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
REQ-022 dx SHALL equal {byte0[4], byte1}; if byte0[6]=1, dx SHALL be 0.
REQ-023 dy SHALL equal {byte0[5], byte2}; if byte0[7]=1, dy SHALL be 0.
REQ-024 xpos SHALL become clamp(xpos + dx, 0, XMAX), computed with a signed intermediate of at least 10 bits.
REQ-025 ypos SHALL become clamp(ypos - dy, 0, YMAX), computed with a signed intermediate of at least 10 bits.
REQ-026 A timeout counter SHALL clear on every accepted byte and count while in WAIT1 or WAIT2.
REQ-027 When the timeout counter reaches TIMEOUT_CYCLES with no byte_valid in that cycle, the block SHALL return to WAIT0, drop the partial packet and leave the outputs unchanged.
REQ-028 If byte_valid coincides with the timeout limit, the byte SHALL win and be processed normally.
REQ-029 The timeout counter SHALL hold at 0 while in WAIT0.
REQ-030 Outputs SHALL change only on a packet commit or on reset.

Reset
REQ-031 On a clk edge with rst=1, the FSM SHALL go to WAIT0 and the timeout counter and latched bytes SHALL clear.
REQ-032 On reset: buttons=0, dx=0, dy=0, packet_ready=0 and sync_err=0.
REQ-033 On reset: xpos=XMAX/2 (127) and ypos=YMAX/2 (95), using integer division.
REQ-034 Reset asserted mid-packet SHALL abandon the packet; the first byte after reset SHALL be treated as byte0.
REQ-035 rst SHALL override byte_valid in the same cycle.

Verification
REQ-036 Bytes 0x09,0x05,0x03 -> buttons=001, dx=+5, dy=+3, xpos 127->132, ypos 95->92, one packet_ready pulse one cycle after the third strobe.
REQ-037 From reset, bytes 0x38,0xFB,0xFE -> dx=-5 (0x1FB), dy=-2 (0x1FE), xpos=122, ypos=97.
REQ-038 Byte 0x00 then 0x08,0x00,0x00 -> one sync_err pulse after 0x00, then one packet with dx=dy=0 and buttons=000.
REQ-039 Bytes 0x08,0x10, then TIMEOUT_CYCLES idle cycles, then 0x09,0x01,0x01 -> no packet for the first pair; second packet gives buttons=001, xpos=128, ypos=94.
REQ-040 Two packets 0x08,0xFF,0x00 -> xpos saturates at 255; packet 0x48,0x10,0x00 -> dx=0 and xpos unchanged.
REQ-041 Bytes 0x09,0x05, then rst for 1 cycle, then 0x0A,0x01,0x01 -> no packet from the first pair; buttons=010, xpos=128, ypos=94.
